dual_port_mem_responder: RTL and testbench

Memory-side responder for the CPU's two memory ports: port a (instruction fetch) and port b (load/store queue). It serves read and write requests from both ports against one word-addressed storage array. It arbitrates between the ports, applies a fixed access latency, and returns a single-cycle `mem_resp` pulse to the port it served. It sits below the datapath as the simulation and back-end memory model, and is the other end of the `mem_*_a` / `mem_*_b` initiator interface.

---
 rtl/dual_port_mem_responder_if.sv | 20 ++
 rtl/dual_port_mem_responder.sv | 143 ++++++++++++++
 tb/tb_dual_port_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dual_port_mem_responder_if.sv
// One memory port (read/write request, byte mask, address, data, response pulse).
// The initiator drives through master; the memory responder uses slave.
interface dual_port_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/dual_port_mem_responder.sv
// Two-port word-addressed memory model with fixed access latency and single-cycle resp.
// Define MEM_RR_ARB_EN for round-robin arbitration; otherwise port a wins every tie.
module dual_port_mem_responder #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dual_port_mem_responder_if.slave  port_a,
  dual_port_mem_responder_if.slave  port_b
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                 r_state, w_next;
  logic [3:0]             r_cnt;
  logic                   r_port;   // 1 = port b
  logic                   r_rd, r_wr;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [15:0]            r_wdata;
  logic [1:0]             r_mask;
  logic [15:0]            r_rdata_a, r_rdata_b;
  logic [15:0]            r_mem [DEPTH];

  logic                   w_req_a, w_req_b, w_sel_b, w_accept, w_access;
  logic                   w_in_rd, w_in_wr;
  logic [ADDR_BITS-1:0]   w_in_idx;
  logic [15:0]            w_in_wdata;
  logic [1:0]             w_in_mask;
  logic                   w_port, w_acc_rd, w_acc_wr;
  logic [ADDR_BITS-1:0]   w_acc_idx;
  logic [15:0]            w_acc_wdata, w_rd_word;
  logic [1:0]             w_acc_mask;
  logic                   w_unused;

  assign w_req_a  = port_a.mem_read | port_a.mem_write;
  assign w_req_b  = port_b.mem_read | port_b.mem_write;
  assign w_unused = ^{port_a.mem_address, port_b.mem_address};

`ifdef MEM_RR_ARB_EN
  logic r_last_b;
  assign w_sel_b = w_req_b & (~w_req_a | ~r_last_b);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_b <= 1'b1;
    else if (w_accept) r_last_b <= w_sel_b;
  end
`else
  assign w_sel_b = w_req_b & ~w_req_a;
`endif

  always_comb begin
    w_in_rd    = w_sel_b ? port_b.mem_read        : port_a.mem_read;
    w_in_wr    = w_sel_b ? port_b.mem_write       : port_a.mem_write;
    w_in_idx   = w_sel_b ? port_b.mem_address[ADDR_BITS:1] : port_a.mem_address[ADDR_BITS:1];
    w_in_wdata = w_sel_b ? port_b.mem_wdata       : port_a.mem_wdata;
    w_in_mask  = w_sel_b ? port_b.mem_byte_enable : port_a.mem_byte_enable;
  end

  // With LATENCY==1 the access happens on the acceptance edge, straight from the inputs.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_port = w_sel_b;  w_acc_rd = w_in_rd;  w_acc_wr = w_in_wr;
      w_acc_idx = w_in_idx;  w_acc_wdata = w_in_wdata;  w_acc_mask = w_in_mask;
    end else begin
      w_port = r_port;   w_acc_rd = r_rd;     w_acc_wr = r_wr;
      w_acc_idx = r_idx;     w_acc_wdata = r_wdata;     w_acc_mask = r_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: if (w_req_a || w_req_b) begin
        w_accept = 1'b1;
        if (LATENCY == 1) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end else begin
          w_next   = S_BUSY;
        end
      end
      S_BUSY: if (r_cnt <= 4'd1) begin
        w_access = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rd_word = r_mem[w_acc_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_port    <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_port  <= w_sel_b;
        r_rd    <= w_in_rd;
        r_wr    <= w_in_wr;
        r_idx   <= w_in_idx;
        r_wdata <= w_in_wdata;
        r_mask  <= w_in_mask;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read+write counts as a write and returns 0 on the read data.
      if (w_access && w_acc_rd) begin
        if (w_port) r_rdata_b <= w_acc_wr ? 16'h0000 : w_rd_word;
        else        r_rdata_a <= w_acc_wr ? 16'h0000 : w_rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_access && w_acc_wr) begin
      if (w_acc_mask[0]) r_mem[w_acc_idx][7:0]  <= w_acc_wdata[7:0];
      if (w_acc_mask[1]) r_mem[w_acc_idx][15:8] <= w_acc_wdata[15:8];
    end
  end

  assign port_a.mem_resp  = (r_state == S_RESP) & ~r_port;
  assign port_b.mem_resp  = (r_state == S_RESP) &  r_port;
  assign port_a.mem_rdata = r_rdata_a;
  assign port_b.mem_rdata = r_rdata_b;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 3 and 1); stimulus pushes expected responses,
// per-DUT monitors pop and compare port, response cycle and read data.
module tb_dual_port_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp_a3 = 0, resp_b3 = 0;

  typedef struct {
    bit          port;
    logic [15:0] rdata;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  dual_port_mem_responder_if ia3();
  dual_port_mem_responder_if ib3();
  dual_port_mem_responder_if ia1();
  dual_port_mem_responder_if ib1();

  dual_port_mem_responder #(.LATENCY(3), .ADDR_BITS(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .port_a(ia3), .port_b(ib3));
  dual_port_mem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .port_a(ia1), .port_b(ib1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_port(input int d, input bit p, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] m);
    case ({d == 1, p})
      2'b00: begin ia3.mem_read = rd; ia3.mem_write = wr; ia3.mem_address = addr;
                   ia3.mem_wdata = wd; ia3.mem_byte_enable = m; end
      2'b01: begin ib3.mem_read = rd; ib3.mem_write = wr; ib3.mem_address = addr;
                   ib3.mem_wdata = wd; ib3.mem_byte_enable = m; end
      2'b10: begin ia1.mem_read = rd; ia1.mem_write = wr; ia1.mem_address = addr;
                   ia1.mem_wdata = wd; ia1.mem_byte_enable = m; end
      default: begin ib1.mem_read = rd; ib1.mem_write = wr; ib1.mem_address = addr;
                   ib1.mem_wdata = wd; ib1.mem_byte_enable = m; end
    endcase
  endtask

  // Called #1 after edge k with the DUT idle: accept at k+1, resp seen in cycle k+lat.
  task automatic do_req(input int d, input bit p, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] m,
                        input bit chk, input logic [15:0] exp_rd);
    exp_t e;
    int   lat;
    lat = (d == 1) ? 1 : 3;
    e.port = p; e.rdata = exp_rd; e.cyc = cyc + lat; e.chk = chk;
    if (d == 1) q1.push_back(e); else q3.push_back(e);
    set_port(d, p, rd, wr, addr, wd, m);
    repeat (lat + 1) tick();
    set_port(d, p, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic push3(input bit p, input logic [15:0] rd, input int c);
    exp_t e;
    e.port = p; e.rdata = rd; e.cyc = c; e.chk = 1'b1;
    q3.push_back(e);
  endtask

  task automatic mon(input string name, input bit ra, input bit rb,
                     input logic [15:0] da, input logic [15:0] db, inout exp_t q[$]);
    exp_t e;
    logic [15:0] d;
    bit ok;
    if (ra && rb) begin
      checks++; errors++;
      $display("FAIL %s both_resp: got both ports at cycle %0d, want one", name, cyc);
    end else if (ra || rb) begin
      checks++;
      d = rb ? db : da;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_resp: got port %0d at cycle %0d, want none", name, rb, cyc);
      end else begin
        e  = q.pop_front();
        ok = (e.port == rb) && (e.cyc == cyc) && (!e.chk || d === e.rdata);
        if (!ok) begin
          errors++;
          $display("FAIL %s resp: got port %0d cyc %0d rdata %h, want port %0d cyc %0d rdata %h",
                   name, rb, cyc, d, e.port, e.cyc, e.chk ? e.rdata : d);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ia3.mem_resp) resp_a3++;
      if (ib3.mem_resp) resp_b3++;
      mon("lat3", ia3.mem_resp, ib3.mem_resp, ia3.mem_rdata, ib3.mem_rdata, q3);
      mon("lat1", ia1.mem_resp, ib1.mem_resp, ia1.mem_rdata, ib1.mem_rdata, q1);
    end
  end

  initial begin
    int k, na, nb;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        set_port(d == 0 ? 3 : 1, p[0], 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    repeat (2) tick();
    check("rst_resp_a3", {15'd0, ia3.mem_resp}, 16'h0);
    check("rst_resp_b3", {15'd0, ib3.mem_resp}, 16'h0);
    check("rst_rdata_a3", ia3.mem_rdata, 16'h0);
    check("rst_rdata_b3", ib3.mem_rdata, 16'h0);
    check("rst_resp_a1", {15'd0, ia1.mem_resp}, 16'h0);
    check("rst_rdata_b1", ib1.mem_rdata, 16'h0);
    rst_n = 1'b1;

    // preload word 5, then single read on a
    do_req(3, 1'b0, 1'b0, 1'b1, 16'h000A, 16'h1234, 2'b11, 1'b0, 16'h0);
    do_req(3, 1'b0, 1'b1, 1'b0, 16'h000A, 16'h0, 2'b00, 1'b1, 16'h1234);
    // high-byte masked write from b, read back on b
    do_req(3, 1'b1, 1'b0, 1'b1, 16'h000A, 16'hABCD, 2'b10, 1'b0, 16'h0);
    do_req(3, 1'b1, 1'b1, 1'b0, 16'h000A, 16'h0, 2'b00, 1'b1, 16'hAB34);
    // read+write acts as write with zero read data
    do_req(3, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h5555, 2'b11, 1'b1, 16'h0000);
    do_req(3, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, 1'b1, 16'h5555);
    do_req(3, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 2'b00, 1'b1, 16'h5555);

    // reset one cycle after a write is accepted discards it
    do_req(3, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 2'b11, 1'b0, 16'h0);
    na = resp_a3;
    set_port(3, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11);
    tick();
    tick();
    rst_n = 1'b0;
    set_port(3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    #1;
    check("midrst_resp_a", {15'd0, ia3.mem_resp}, 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_no_resp", 16'(resp_a3 - na), 16'h0);
    do_req(3, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 1'b1, 16'h0000);

    // simultaneous continuous requests from reset
    rst_n = 1'b0;
    set_port(3, 1'b0, 1'b1, 1'b0, 16'h000A, 16'h0, 2'b00);
    set_port(3, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    repeat (2) tick();
    nb = resp_b3;
    rst_n = 1'b1;
    k = cyc;
`ifdef MEM_RR_ARB_EN
    push3(1'b0, 16'hAB34, k + 3);
    push3(1'b1, 16'h5555, k + 7);
    push3(1'b0, 16'hAB34, k + 11);
    push3(1'b1, 16'h5555, k + 15);
`else
    push3(1'b0, 16'hAB34, k + 3);
    push3(1'b0, 16'hAB34, k + 7);
    push3(1'b0, 16'hAB34, k + 11);
    push3(1'b0, 16'hAB34, k + 15);
`endif
    while (cyc < k + 16) tick();
    set_port(3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(3, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
`ifdef MEM_RR_ARB_EN
    check("arb_b_count", 16'(resp_b3 - nb), 16'd2);
`else
    check("arb_b_count", 16'(resp_b3 - nb), 16'd0);
`endif
    repeat (6) tick();

    // LATENCY=1 with address wrap: 0x0800 aliases word 0
    do_req(1, 1'b0, 1'b0, 1'b1, 16'h0800, 16'h00FF, 2'b11, 1'b0, 16'h0);
    do_req(1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00, 1'b1, 16'h00FF);
    do_req(1, 1'b1, 1'b1, 1'b0, 16'hF801, 16'h0, 2'b00, 1'b1, 16'h00FF);

    repeat (4) tick();
    check("q3_drained", 16'(q3.size()), 16'h0);
    check("q1_drained", 16'(q1.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
